// File: rtl/byte_serializer_pkg.sv
// Shared defaults and state type for the MSB-first byte serializer.
package byte_serializer_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DIV_W_DEF  = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-period down-counter: loads a period, counts down to zero, flags zero.
module ser_bit_timer #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   input  logic             dec,
   output logic [DIV_W-1:0] cnt,
   output logic             zero
);

   logic [DIV_W-1:0] cnt_reg;

   // A load always wins over a decrement; the count never wraps below zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - DIV_W'(1);
      end
   end

   assign cnt  = cnt_reg;
   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial shifter, MSB first, with a programmable bit period and back-to-back frames.
module byte_serializer
   import byte_serializer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [DIV_W-1:0]  div,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              bit_strobe,
   output logic              frame_done
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   ser_state_t        state_reg, state_next;
   logic [DATA_W-1:0] shreg_reg, shreg_next;
   logic [DIV_W-1:0]  div_q_reg, div_q_next;
   logic [IDX_W-1:0]  bit_idx_reg, bit_idx_next;

   logic [DIV_W-1:0]  cnt;
   logic              cnt_zero;
   logic              timer_load;
   logic              timer_dec;
   logic [DIV_W-1:0]  timer_val;
   logic              last_cycle;
   logic              accept;

   ser_bit_timer #(
      .DIV_W (DIV_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .dec      (timer_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   // Final cycle of bit 0: the only SHIFT cycle where a new word may be taken.
   assign last_cycle = (state_reg == SHIFT) && cnt_zero && (bit_idx_reg == '0);
   assign data_ready = (state_reg == IDLE) || last_cycle;
   assign accept     = data_valid && data_ready;

   always_comb begin
      state_next   = state_reg;
      shreg_next   = shreg_reg;
      div_q_next   = div_q_reg;
      bit_idx_next = bit_idx_reg;
      timer_load   = 1'b0;
      timer_dec    = 1'b0;
      timer_val    = div_q_reg;

      if (accept) begin
         // Same load path whether starting from IDLE or chaining frames.
         state_next   = SHIFT;
         shreg_next   = data_in;
         div_q_next   = div;
         bit_idx_next = IDX_W'(DATA_W - 1);
         timer_load   = 1'b1;
         timer_val    = div;
      end else if (state_reg == SHIFT) begin
         if (!cnt_zero) begin
            timer_dec = 1'b1;
         end else if (bit_idx_reg != '0) begin
            shreg_next   = {shreg_reg[DATA_W-2:0], 1'b0};
            bit_idx_next = bit_idx_reg - IDX_W'(1);
            timer_load   = 1'b1;
            timer_val    = div_q_reg;
         end else begin
            state_next = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         shreg_reg   <= '0;
         div_q_reg   <= '0;
         bit_idx_reg <= '0;
      end else begin
         state_reg   <= state_next;
         shreg_reg   <= shreg_next;
         div_q_reg   <= div_q_next;
         bit_idx_reg <= bit_idx_next;
      end
   end

   assign ser_valid  = (state_reg == SHIFT);
   assign ser_out    = ser_valid && shreg_reg[DATA_W-1];
   assign bit_strobe = ser_valid && (cnt == div_q_reg);
   assign frame_done = last_cycle;

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: vector table, reset corner case, random loopback streams.
module tb_byte_serializer;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic [7:0] div;
   logic       ser_out;
   logic       ser_valid;
   logic       bit_strobe;
   logic       frame_done;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] tx_q[$];

   typedef struct {
      logic [7:0] word;
      int         d;
      bit         scramble;
      int         exp_len;
   } vec_t;

   vec_t vecs[6];

   byte_serializer #(
      .DATA_W (8),
      .DIV_W  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .div        (div),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .bit_strobe (bit_strobe),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required $finish before 2000000 ns");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, required %0h", name, $time, got, exp);
      end
   endtask

   task automatic present(input int d);
      data_in    = tx_q[0];
      div        = 8'(d);
      data_valid = 1'b1;
   endtask

   // Words in tx_q are offered back to back with data_valid held high; each
   // frame cycle is compared to the frame rule: bit (7 - k/(d+1)) of the word.
   task automatic body(input int d, input int per, input bit scramble);
      logic [7:0] rx;
      logic [4:0] exp_v;
      @(negedge clk);
      chk("idle_ready", {data_ready, ser_valid, frame_done}, 3'b100);
      @(posedge clk); #1;
      for (int w = 0; w < tx_q.size(); w++) begin
         if (w + 1 < tx_q.size()) data_in = tx_q[w+1];
         else data_valid = 1'b0;
         rx = '0;
         for (int k = 0; k < per; k++) begin
            if (scramble && !data_valid) begin
               data_in = 8'($urandom);
               div     = 8'($urandom);
            end
            @(negedge clk);
            exp_v = {1'b1, tx_q[w][7 - (k / (d + 1))], (k % (d + 1)) == 0,
                     k == per - 1, k == per - 1};
            chk("frame_bits", {ser_valid, ser_out, bit_strobe, frame_done, data_ready}, exp_v);
            if (bit_strobe) rx = {rx[6:0], ser_out};
            @(posedge clk); #1;
         end
         chk("loopback", rx, tx_q[w]);
         $display("frame word=%02h div=%0d received=%02h", tx_q[w], d, rx);
      end
      @(negedge clk);
      chk("idle_after", {data_ready, ser_valid, frame_done}, 3'b100);
   endtask

   task automatic run_stream(input int d, input int per, input bit scramble);
      @(posedge clk); #1;
      present(d);
      body(d, per, scramble);
   endtask

   initial begin
      int g;
      int d;
      int sent;

      vecs[0] = '{word: 8'hA5, d: 0, scramble: 1'b0, exp_len: 8};
      vecs[1] = '{word: 8'h81, d: 3, scramble: 1'b0, exp_len: 32};
      vecs[2] = '{word: 8'hFF, d: 1, scramble: 1'b1, exp_len: 16};
      vecs[3] = '{word: 8'h00, d: 2, scramble: 1'b1, exp_len: 24};
      vecs[4] = '{word: 8'h3C, d: 7, scramble: 1'b0, exp_len: 64};
      vecs[5] = '{word: 8'h01, d: 0, scramble: 1'b1, exp_len: 8};

      rst        = 1'b1;
      data_valid = 1'b0;
      data_in    = 8'h00;
      div        = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {data_ready, ser_valid, ser_out, bit_strobe, frame_done}, 5'b10000);

      // Vector 0 is offered on the very first edge with rst low.
      for (int i = 0; i < 6; i++) begin
         tx_q.delete();
         tx_q.push_back(vecs[i].word);
         if (i == 0) begin
            @(posedge clk); #1;
            rst = 1'b0;
            present(vecs[i].d);
            body(vecs[i].d, vecs[i].exp_len, vecs[i].scramble);
         end else begin
            run_stream(vecs[i].d, vecs[i].exp_len, vecs[i].scramble);
         end
      end

      // Two words held on data_valid: 16 contiguous serial cycles.
      tx_q.delete();
      tx_q.push_back(8'hF0);
      tx_q.push_back(8'h0F);
      run_stream(0, 8, 1'b0);

      // Reset in cycle 10 of a div=2 frame of 0x55 aborts it silently.
      tx_q.delete();
      tx_q.push_back(8'h55);
      @(posedge clk); #1;
      present(2);
      @(posedge clk); #1;
      data_valid = 1'b0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk("pre_reset_bits", {ser_valid, ser_out, frame_done},
             {1'b1, tx_q[0][7 - (k / 3)], 1'b0});
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("reset_cycle_valid", {ser_valid, frame_done}, 2'b10);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("after_reset", {ser_valid, ser_out, data_ready, frame_done, bit_strobe}, 5'b00100);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("no_done_after_reset", {ser_valid, frame_done}, 2'b00);
      end
      tx_q.delete();
      tx_q.push_back(8'h3C);
      run_stream(2, 24, 1'b0);

      // Random words in short bursts with random bit periods.
      sent = 0;
      while (sent < 256) begin
         g = $urandom_range(1, 3);
         if (g > 256 - sent) g = 256 - sent;
         d = $urandom_range(0, 3);
         tx_q.delete();
         for (int i = 0; i < g; i++) tx_q.push_back(8'($urandom));
         run_stream(d, 8 * (d + 1), 1'($urandom_range(0, 1)));
         sent += g;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
